// File: rtl/noc_out_alloc_pkg.sv
// noc_out_alloc_pkg: shared types and helpers for the wormhole output-port allocator.
//   state_e  : allocator FSM states (IDLE, LOCKED)
//   N_IN_DEF / FLIT_W_DEF / WDOG_CYCLES_DEF : default build parameters
//   oh2idx   : one-hot to index conversion (lowest set bit wins)
package noc_out_alloc_pkg;

  localparam int unsigned N_IN_DEF        = 5;
  localparam int unsigned FLIT_W_DEF      = 34;
  localparam int unsigned WDOG_CYCLES_DEF = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Index of the set bit of a one-hot vector (up to 32 entries); 0 when empty.
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (oh[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// noc_rr_pick: combinational masked priority pick for the round-robin allocator.
//   req_i  [N_IN] : requesting inputs
//   mask_i [N_IN] : priority mask; lowest requester inside the mask wins,
//                   otherwise lowest requester overall (wrap-around)
//   gnt_o  [N_IN] : one-hot winner (zero when no request)
//   any_o         : at least one request present
module noc_rr_pick #(
  parameter int unsigned N_IN = 5
) (
  input  logic [N_IN-1:0] req_i,
  input  logic [N_IN-1:0] mask_i,
  output logic [N_IN-1:0] gnt_o,
  output logic            any_o
);

  logic [N_IN-1:0] masked;
  logic [N_IN-1:0] src;

  // Isolate the lowest set bit of the chosen request vector.
  always_comb begin
    masked = req_i & mask_i;
    src    = (|masked) ? masked : req_i;
    gnt_o  = src & (~src + N_IN'(1));
    any_o  = |req_i;
  end

endmodule

// File: rtl/noc_out_port_alloc.sv
// noc_out_port_alloc: wormhole output-port allocator for one router output.
// Round-robin arbitration among N_IN inputs; the grant is locked from head
// to tail flit and the winner's stream is forwarded combinationally.
// Optional macro NOC_OUT_ALLOC_WDOG_EN adds a stall watchdog that breaks a
// lock after WDOG_CYCLES stalled cycles and raises sticky err_o.
// Ports:
//   clk, arst (async, active-low)
//   valid_i/flit_i/tail_i/ready_o : per-input flit stream
//   valid_o/flit_o/tail_o/ready_i : output link handshake
//   grant_o : one-hot owner, busy_o : lock held, err_o : sticky watchdog error
module noc_out_port_alloc
  import noc_out_alloc_pkg::*;
#(
  parameter int unsigned N_IN        = N_IN_DEF,
  parameter int unsigned FLIT_W      = FLIT_W_DEF,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_IN-1:0]          valid_i,
  input  logic [N_IN*FLIT_W-1:0]   flit_i,
  input  logic [N_IN-1:0]          tail_i,
  output logic [N_IN-1:0]          ready_o,
  output logic                     valid_o,
  output logic [FLIT_W-1:0]        flit_o,
  output logic                     tail_o,
  input  logic                     ready_i,
  output logic [N_IN-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     err_o
);

  if (N_IN < 2) begin : g_bad_n_in
    $error("noc_out_port_alloc: N_IN must be at least 2");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("noc_out_port_alloc: WDOG_CYCLES must be at least 2");
  end

  state_e          state_q, state_d;
  logic [N_IN-1:0] grant_q, grant_d;
  logic [N_IN-1:0] mask_q,  mask_d;
  logic [N_IN-1:0] pick_gnt;
  logic            pick_any;
  logic [N_IN-1:0] mask_above;
  logic            xfer;
  logic            release_c;

`ifdef NOC_OUT_ALLOC_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  noc_rr_pick #(.N_IN(N_IN)) u_pick (
    .req_i  (valid_i),
    .mask_i (mask_q),
    .gnt_o  (pick_gnt),
    .any_o  (pick_any)
  );

  // Next mask after the current owner finishes: bits strictly above the owner,
  // all ones when the owner is the top input.
  always_comb begin
    int unsigned g;
    g = oh2idx(32'(grant_q));
    mask_above = '1;
    if (g != N_IN - 1) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        mask_above[k] = (k > g);
      end
    end
  end

  // FSM next state and forwarding mux.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    mask_d    = mask_q;
    valid_o   = 1'b0;
    flit_o    = '0;
    tail_o    = 1'b0;
    ready_o   = '0;
    xfer      = 1'b0;
    release_c = 1'b0;
`ifdef NOC_OUT_ALLOC_WDOG_EN
    cnt_d     = '0;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        for (int unsigned k = 0; k < N_IN; k++) begin
          if (grant_q[k]) begin
            valid_o = valid_i[k];
            flit_o  = flit_i[k*FLIT_W +: FLIT_W];
            tail_o  = tail_i[k];
          end
        end
        ready_o   = grant_q & {N_IN{ready_i}};
        xfer      = valid_o & ready_i;
        release_c = xfer & tail_o;
`ifdef NOC_OUT_ALLOC_WDOG_EN
        // Stall counter: any transfer clears it; the limit breaks the lock.
        if (!xfer) begin
          if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
            release_c = 1'b1;
            err_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        if (release_c) begin
          state_d = IDLE;
          grant_d = '0;
          mask_d  = mask_above;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, lock and priority registers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      grant_q <= '0;
      mask_q  <= '1;
`ifdef NOC_OUT_ALLOC_WDOG_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
`ifdef NOC_OUT_ALLOC_WDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == LOCKED);
`ifdef NOC_OUT_ALLOC_WDOG_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// tb_noc_out_port_alloc: directed self-checking bench for noc_out_port_alloc
// (N_IN=5, FLIT_W=34, WDOG_CYCLES=8).
module tb_noc_out_port_alloc;

  localparam int unsigned N_IN   = 5;
  localparam int unsigned FLIT_W = 34;
  localparam int unsigned WDOG   = 8;

  logic                   clk;
  logic                   arst;
  logic [N_IN-1:0]        valid_i;
  logic [N_IN*FLIT_W-1:0] flit_i;
  logic [N_IN-1:0]        tail_i;
  logic [N_IN-1:0]        ready_o;
  logic                   valid_o;
  logic [FLIT_W-1:0]      flit_o;
  logic                   tail_o;
  logic                   ready_i;
  logic [N_IN-1:0]        grant_o;
  logic                   busy_o;
  logic                   err_o;

  logic [FLIT_W-1:0] fl [N_IN];

  int n_checks;
  int n_fail;

  noc_out_port_alloc #(
    .N_IN        (N_IN),
    .FLIT_W      (FLIT_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .valid_i (valid_i),
    .flit_i  (flit_i),
    .tail_i  (tail_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .flit_o  (flit_o),
    .tail_o  (tail_o),
    .ready_i (ready_i),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N_IN; k++) flit_i[k*FLIT_W +: FLIT_W] = fl[k];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flits();
    for (int k = 0; k < N_IN; k++) fl[k] = FLIT_W'(34'h2_A000_0000 + 34'(k) * 34'h100);
  endtask

  task automatic do_reset();
    arst    = 1'b0;
    valid_i = '0;
    tail_i  = '0;
    ready_i = 1'b0;
    set_flits();
    repeat (2) tick();
    arst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    arst    = 1'b0;
    valid_i = 5'b11111;
    tail_i  = 5'b11111;
    ready_i = 1'b1;
    set_flits();
    repeat (2) tick();
    n_checks++; if (grant_o !== 5'b00000) begin n_fail++; $display("FAIL reset_grant got %b exp 00000", grant_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o got %b exp 0", valid_o); end
    n_checks++; if (ready_o !== 5'b00000) begin n_fail++; $display("FAIL reset_ready_o got %b exp 00000", ready_o); end
    valid_i = '0;
    arst    = 1'b1;
    #1;
  endtask

  task automatic test_rr_basic();
    logic [N_IN-1:0] exp_g [5];
    int              exp_i [5];
    do_reset();
    exp_g[0] = 5'b00010; exp_i[0] = 1;
    exp_g[1] = 5'b00000; exp_i[1] = 0;
    exp_g[2] = 5'b00100; exp_i[2] = 2;
    exp_g[3] = 5'b00000; exp_i[3] = 0;
    exp_g[4] = 5'b00010; exp_i[4] = 1;
    tail_i  = 5'b11111;
    ready_i = 1'b1;
    valid_i = 5'b00110;
    #1;
    n_checks++; if (valid_o !== 1'b0 || ready_o !== 5'b00000) begin n_fail++; $display("FAIL rr_idle_out got valid_o=%b ready_o=%b exp 0 00000", valid_o, ready_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (grant_o !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", i, grant_o, exp_g[i]); end
      if (exp_g[i] != 0) begin
        n_checks++; if (flit_o !== fl[exp_i[i]] || valid_o !== 1'b1 || ready_o !== exp_g[i]) begin n_fail++; $display("FAIL rr_flit[%0d] got %h/%b/%b exp %h/1/%b", i, flit_o, valid_o, ready_o, fl[exp_i[i]], exp_g[i]); end
      end
    end
    valid_i = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    ready_i   = 1'b1;
    valid_i   = 5'b01001;
    tail_i    = 5'b01000;
    fl[0]     = FLIT_W'(34'h0_0000_0F00);
    tick();
    n_checks++; if (grant_o !== 5'b00001 || flit_o !== FLIT_W'(34'h0_0000_0F00)) begin n_fail++; $display("FAIL stall_head got %b %h exp 00001 000000f00", grant_o, flit_o); end
    tick();
    fl[0]   = FLIT_W'(34'h0_0000_0F01);
    ready_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (grant_o !== 5'b00001 || ready_o !== 5'b00000 || flit_o !== FLIT_W'(34'h0_0000_0F01)) begin n_fail++; $display("FAIL stall_hold[%0d] got %b %b %h exp 00001 00000 000000f01", i, grant_o, ready_o, flit_o); end
      tick();
    end
    ready_i = 1'b1;
    #1;
    n_checks++; if (ready_o !== 5'b00001 || flit_o !== FLIT_W'(34'h0_0000_0F01) || tail_o !== 1'b0) begin n_fail++; $display("FAIL stall_resume got %b %h %b exp 00001 000000f01 0", ready_o, flit_o, tail_o); end
    tick();
    fl[0]     = FLIT_W'(34'h0_0000_0F02);
    tail_i[0] = 1'b1;
    #1;
    n_checks++; if (flit_o !== FLIT_W'(34'h0_0000_0F02) || tail_o !== 1'b1 || grant_o !== 5'b00001) begin n_fail++; $display("FAIL stall_tail got %h %b %b exp 000000f02 1 00001", flit_o, tail_o, grant_o); end
    tick();
    valid_i[0] = 1'b0;
    #1;
    n_checks++; if (grant_o !== 5'b00000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %b %b exp 00000 0", grant_o, busy_o); end
    tick();
    n_checks++; if (grant_o !== 5'b01000 || flit_o !== fl[3]) begin n_fail++; $display("FAIL stall_next got %b %h exp 01000 %h", grant_o, flit_o, fl[3]); end
    valid_i = '0;
    tick();
  endtask

  task automatic test_all_req();
    logic [N_IN-1:0] eg;
    do_reset();
    ready_i = 1'b1;
    tail_i  = 5'b11111;
    valid_i = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      eg = 5'b00001 << (i % 5);
      tick();
      n_checks++; if (grant_o !== eg || flit_o !== fl[i % 5]) begin n_fail++; $display("FAIL all_grant[%0d] got %b %h exp %b %h", i, grant_o, flit_o, eg, fl[i % 5]); end
      tick();
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL all_gap[%0d] got busy %b exp 0", i, busy_o); end
    end
    valid_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_i = 1'b1;
    tail_i  = 5'b00000;
    valid_i = 5'b00100;
    tick();
    n_checks++; if (grant_o !== 5'b00100) begin n_fail++; $display("FAIL rmid_grant got %b exp 00100", grant_o); end
    tick();
    arst    = 1'b0;
    valid_i = 5'b10101;
    #1;
    n_checks++; if (grant_o !== 5'b00000 || valid_o !== 1'b0 || ready_o !== 5'b00000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_async got %b %b %b %b exp 00000 0 00000 0", grant_o, valid_o, ready_o, busy_o); end
    tick();
    n_checks++; if (grant_o !== 5'b00000) begin n_fail++; $display("FAIL rmid_hold got %b exp 00000", grant_o); end
    arst = 1'b1;
    tick();
    n_checks++; if (grant_o !== 5'b00001) begin n_fail++; $display("FAIL rmid_rearb got %b exp 00001", grant_o); end
    valid_i = '0;
    arst    = 1'b0;
    tick();
    arst    = 1'b1;
  endtask

  task automatic test_winner_drop();
    do_reset();
    ready_i = 1'b1;
    tail_i  = 5'b00000;
    valid_i = 5'b00010;
    tick();
    n_checks++; if (grant_o !== 5'b00010) begin n_fail++; $display("FAIL drop_grant got %b exp 00010", grant_o); end
    tick();
    valid_i = 5'b01101;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (grant_o !== 5'b00010 || ready_o !== 5'b00010 || valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_hold[%0d] got %b %b %b exp 00010 00010 0", i, grant_o, ready_o, valid_o); end
      tick();
    end
    valid_i = 5'b01111;
    tail_i  = 5'b00010;
    #1;
    n_checks++; if (valid_o !== 1'b1 || tail_o !== 1'b1) begin n_fail++; $display("FAIL drop_tail got %b %b exp 1 1", valid_o, tail_o); end
    tick();
    valid_i = 5'b01101;
    tick();
    n_checks++; if (grant_o !== 5'b00100) begin n_fail++; $display("FAIL drop_next got %b exp 00100", grant_o); end
    valid_i = '0;
    arst    = 1'b0;
    tick();
    arst    = 1'b1;
  endtask

  task automatic test_wdog();
    do_reset();
    ready_i = 1'b0;
    tail_i  = 5'b11111;
    valid_i = 5'b01010;
    tick();
    n_checks++; if (grant_o !== 5'b00010 || busy_o !== 1'b1) begin n_fail++; $display("FAIL wdog_grant got %b %b exp 00010 1", grant_o, busy_o); end
    for (int i = 1; i < WDOG; i++) begin
      tick();
      n_checks++; if (busy_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL wdog_stall[%0d] got busy %b err %b exp 1 0", i, busy_o, err_o); end
    end
    tick();
`ifdef NOC_OUT_ALLOC_WDOG_EN
    n_checks++; if (busy_o !== 1'b0 || err_o !== 1'b1 || grant_o !== 5'b00000) begin n_fail++; $display("FAIL wdog_fire got %b %b %b exp 0 1 00000", busy_o, err_o, grant_o); end
    tick();
    n_checks++; if (grant_o !== 5'b01000 || err_o !== 1'b1) begin n_fail++; $display("FAIL wdog_next got %b %b exp 01000 1", grant_o, err_o); end
`else
    n_checks++; if (busy_o !== 1'b1 || err_o !== 1'b0 || grant_o !== 5'b00010) begin n_fail++; $display("FAIL wdog_off got %b %b %b exp 1 0 00010", busy_o, err_o, grant_o); end
    repeat (20) tick();
    n_checks++; if (busy_o !== 1'b1 || grant_o !== 5'b00010 || err_o !== 1'b0) begin n_fail++; $display("FAIL wdog_persist got %b %b %b exp 1 00010 0", busy_o, grant_o, err_o); end
`endif
    valid_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst     = 1'b0;
    valid_i  = '0;
    tail_i   = '0;
    ready_i  = 1'b0;
    set_flits();
    test_reset();
    test_rr_basic();
    test_stall();
    test_all_req();
    test_reset_mid();
    test_winner_drop();
    test_wdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
